// File: rtl/video_rx_pkg.sv
// video_rx_pkg: shared constants and state encoding for the video capture receiver
package video_rx_pkg;
    localparam int H_ACTIVE_480P = 640;
    localparam int V_ACTIVE_480P = 480;
    localparam int WIN_ROW_W = 3;
    localparam int WIN_COL_W = 6;
    typedef logic [1:0] rx_state_t;
    localparam rx_state_t SEEK = 2'd0;
    localparam rx_state_t WAIT = 2'd1;
    localparam rx_state_t ACTIVE = 2'd2;
endpackage

// File: rtl/video_capture_rx_if.sv
// video_capture_rx_if: parallel video bus (syncs, data enable, colour bits)
interface video_capture_rx_if;
    logic hsync, vsync, de, r, g, b;
    modport master(output hsync, vsync, de, r, g, b);
    modport slave(input hsync, vsync, de, r, g, b);
endinterface

// File: rtl/video_capture_rx_capture_bitmap.sv
// capture_bitmap: dual-bank bit store; writes hit the back bank, registered reads the front bank
module capture_bitmap
    import video_rx_pkg::*;
#(
    parameter int WIN_W = 40,
    parameter int WIN_H = 6
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bsel,
    input  logic                 we,
    input  logic                 wr_data,
    input  logic [WIN_ROW_W-1:0] wr_row,
    input  logic [WIN_COL_W-1:0] wr_col,
    input  logic [WIN_ROW_W-1:0] rd_row,
    input  logic [WIN_COL_W-1:0] rd_col,
    output logic                 rd_data
);
    localparam logic [WIN_ROW_W-1:0] ROW_LIM = WIN_ROW_W'(WIN_H);
    localparam logic [WIN_COL_W-1:0] COL_LIM = WIN_COL_W'(WIN_W);
    logic mem [2][WIN_H][WIN_W];
    always_ff @(posedge clk)
        if (we) mem[~bsel][wr_row][wr_col] <= wr_data;
    always_ff @(posedge clk)
        if (!rst_n) rd_data <= 1'b0;
        else rd_data <= (rd_row < ROW_LIM && rd_col < COL_LIM) ? mem[bsel][rd_row][rd_col] : 1'b0;
endmodule

// File: rtl/video_capture_rx.sv
// video_capture_rx: recovers pixel coordinates, checks frame geometry and captures a bitmap window
module video_capture_rx
    import video_rx_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_480P,
    parameter int V_ACTIVE = V_ACTIVE_480P,
    parameter int WIN_W    = 40,
    parameter int WIN_H    = 6,
    parameter int CNT_W    = 10,
    parameter bit SYNC_ACT = 1'b0
)(
    input  logic                 clk_pix,
    input  logic                 rst_pix_n,
    video_capture_rx_if.slave    vid,
    output logic [CNT_W-1:0]     px,
    output logic [CNT_W-1:0]     py,
    output logic                 px_valid,
    output logic                 locked,
    output logic                 line_err,
    output logic                 frame_done,
    output logic [CNT_W-1:0]     meas_line,
    output logic [CNT_W-1:0]     meas_lines,
    input  logic [WIN_ROW_W-1:0] rd_row,
    input  logic [WIN_COL_W-1:0] rd_col,
    output logic                 rd_data
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] H_EXP = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_EXP = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] W_LIM = CNT_W'(WIN_W);
    localparam logic [CNT_W-1:0] H_LIM = CNT_W'(WIN_H);
    logic s1_vs, s2_vs, s1_de, s2_de, s1_r;
    logic vs_rise, de_rise, de_fall, len_bad, eval_bad, frame_bad, bsel, we, swap;
    logic [CNT_W-1:0] x_cnt, y_cnt, x_cur, y_end;
    logic [1:0] good_cnt;
    rx_state_t state;
    assign vs_rise = s1_vs & ~s2_vs;
    assign de_rise = s1_de & ~s2_de;
    assign de_fall = ~s1_de & s2_de;
    assign x_cur = de_rise ? '0 : x_cnt;
    assign len_bad = de_fall && x_cnt != H_EXP;
    // y_end counts a line ending on this cycle, so a coincident vs_rise sees it
    assign y_end = (de_fall && y_cnt != CNT_MAX) ? y_cnt + ONE : y_cnt;
    assign eval_bad = frame_bad | len_bad | (y_end != V_EXP);
    assign swap = vs_rise && state == ACTIVE;
    assign locked = good_cnt == 2'd2;
    assign we = s1_de && x_cur < W_LIM && y_cnt < H_LIM;
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            {s1_vs, s2_vs, s1_de, s2_de, s1_r} <= '0;
            {x_cnt, y_cnt, px, py, meas_line, meas_lines} <= '0;
            {px_valid, line_err, frame_done, frame_bad, bsel} <= '0;
            good_cnt <= 2'd0;
            state <= SEEK;
        end else begin
            s1_vs <= vid.vsync ~^ SYNC_ACT;
            s2_vs <= s1_vs;
            s1_de <= vid.de;
            s2_de <= s1_de;
            s1_r <= vid.r;
            x_cnt <= de_rise ? ONE : (s1_de && x_cnt != CNT_MAX) ? x_cnt + ONE : x_cnt;
            y_cnt <= vs_rise ? '0 : y_end;
            px <= x_cur;
            py <= y_cnt;
            px_valid <= s1_de;
            if (de_fall) meas_line <= x_cnt;
            if (len_bad && locked) line_err <= 1'b1;
            frame_bad <= vs_rise ? 1'b0 : frame_bad | len_bad;
            frame_done <= swap;
            if (swap) begin
                meas_lines <= y_end;
                bsel <= ~bsel;
                good_cnt <= eval_bad ? 2'd0 : locked ? 2'd2 : good_cnt + 2'd1;
            end
            state <= state == SEEK ? (vs_rise ? WAIT : SEEK) :
                     state == WAIT ? (de_rise ? ACTIVE : WAIT) : ACTIVE;
        end
    end
    capture_bitmap #(.WIN_W(WIN_W), .WIN_H(WIN_H)) u_bitmap (
        .clk(clk_pix),
        .rst_n(rst_pix_n),
        .bsel(bsel),
        .we(we),
        .wr_data(s1_r),
        .wr_row(y_cnt[WIN_ROW_W-1:0]),
        .wr_col(x_cur[WIN_COL_W-1:0]),
        .rd_row(rd_row),
        .rd_col(rd_col),
        .rd_data(rd_data)
    );
endmodule

// File: tb/tb_video_capture_rx.sv
// tb_video_capture_rx: directed frames on a reduced 48x8 geometry with hand-computed expectations
module tb_video_capture_rx;
    import video_rx_pkg::*;
    localparam int H = 48;
    localparam int V = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    video_capture_rx_if vid();
    logic [9:0] px, py, meas_line, meas_lines;
    logic px_valid, locked, line_err, frame_done, rd_data;
    logic [2:0] rd_row = '0;
    logic [5:0] rd_col = '0;
    int total = 0, bad = 0, fd_cnt = 0, fd_save = 0;
    bit pat_on = 0, probe_on = 0, rst_on = 0;

    video_capture_rx #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_pix(clk), .rst_pix_n(rst_n), .vid(vid),
        .px(px), .py(py), .px_valid(px_valid), .locked(locked), .line_err(line_err),
        .frame_done(frame_done), .meas_line(meas_line), .meas_lines(meas_lines),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data)
    );

    always @(negedge clk) if (frame_done) fd_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " px"}, 32'(px), 0);
        check({tag, " py"}, 32'(py), 0);
        check({tag, " px_valid"}, 32'(px_valid), 0);
        check({tag, " locked"}, 32'(locked), 0);
        check({tag, " line_err"}, 32'(line_err), 0);
        check({tag, " frame_done"}, 32'(frame_done), 0);
        check({tag, " meas_line"}, 32'(meas_line), 0);
        check({tag, " meas_lines"}, 32'(meas_lines), 0);
        check({tag, " rd_data"}, 32'(rd_data), 0);
    endtask

    task automatic idle(input int n, input logic vs);
        repeat (n) begin
            vid.de = 1'b0;
            vid.r = 1'b0;
            vid.vsync = vs;
            @(negedge clk);
        end
    endtask

    task automatic send_line(input int y, input int len, input bit tight);
        vid.hsync = 1'b1;
        for (int x = 0; x < len; x++) begin
            vid.de = 1'b1;
            vid.r = pat_on && ((x == 5 && y == 2) || (x == 39 && y == 5) || (x == 40 && y == 0));
            @(negedge clk);
            if (probe_on && y == 3 && x == 10) begin
                check("probe px", 32'(px), 9);
                check("probe py", 32'(py), 3);
                check("probe px_valid", 32'(px_valid), 1);
            end
            if (rst_on && y == 3 && x == 10) begin
                rst_n = 1'b0;
                @(negedge clk);
                check_zero("midrst");
                rst_n = 1'b1;
            end
        end
        vid.de = 1'b0;
        vid.r = 1'b0;
        if (tight) vid.vsync = 1'b0;
        repeat (2) @(negedge clk);
        vid.hsync = 1'b0;
        repeat (2) @(negedge clk);
        vid.hsync = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame(input int nlines, input int last_len, input bit tight);
        vid.vsync = 1'b1;
        for (int y = 0; y < nlines; y++)
            send_line(y, (y == nlines - 1) ? last_len : H, tight && y == nlines - 1);
        if (!tight) idle(10, 1'b1);
        idle(10, 1'b0);
        idle(10, 1'b1);
    endtask

    initial begin
        vid.hsync = 1'b1; vid.vsync = 1'b1; vid.de = 1'b0;
        vid.r = 1'b0; vid.g = 1'b0; vid.b = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        frame(V, H, 0);
        check("A locked", 32'(locked), 0);
        check("A frame_done count", 32'(fd_cnt), 0);
        frame(V, H, 0);
        check("B locked", 32'(locked), 0);
        check("B meas_lines", 32'(meas_lines), V);
        check("B frame_done count", 32'(fd_cnt), 1);
        frame(V, H, 0);
        check("C locked", 32'(locked), 1);
        check("C meas_line", 32'(meas_line), H);
        check("C meas_lines", 32'(meas_lines), V);
        check("C line_err", 32'(line_err), 0);
        check("C frame_done count", 32'(fd_cnt), 2);
        pat_on = 1; probe_on = 1;
        frame(V, H, 0);
        pat_on = 0; probe_on = 0;
        check("D locked", 32'(locked), 1);
        check("D frame_done count", 32'(fd_cnt), 3);
        for (int rr = 0; rr < 8; rr++)
            for (int cc = 0; cc < 64; cc++) begin
                rd_row = 3'(rr);
                rd_col = 6'(cc);
                @(negedge clk);
                check($sformatf("rd(%0d,%0d)", rr, cc), 32'(rd_data),
                      32'((rr == 2 && cc == 5) || (rr == 5 && cc == 39)));
            end
        frame(V, H - 1, 0);
        check("E meas_line", 32'(meas_line), H - 1);
        check("E line_err", 32'(line_err), 1);
        check("E locked", 32'(locked), 0);
        check("E meas_lines", 32'(meas_lines), V);
        frame(V, H, 0);
        check("F locked", 32'(locked), 0);
        check("F line_err sticky", 32'(line_err), 1);
        frame(V, H, 0);
        check("G locked", 32'(locked), 1);
        frame(V - 1, H, 0);
        check("H meas_lines", 32'(meas_lines), V - 1);
        check("H locked", 32'(locked), 0);
        frame(V, H, 0);
        check("I locked", 32'(locked), 0);
        frame(V, H, 0);
        check("J locked", 32'(locked), 1);
        check("J meas_lines", 32'(meas_lines), V);
        frame(V, H, 1);
        check("K meas_lines", 32'(meas_lines), V);
        check("K meas_line", 32'(meas_line), H);
        check("K locked", 32'(locked), 1);
        fd_save = fd_cnt;
        rst_on = 1;
        frame(V, H, 0);
        rst_on = 0;
        check("L no swap after reset", 32'(fd_cnt), 32'(fd_save));
        check("L locked", 32'(locked), 0);
        frame(V, H, 0);
        check("M swap", 32'(fd_cnt), 32'(fd_save + 1));
        check("M meas_lines", 32'(meas_lines), V);
        check("M line_err", 32'(line_err), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_capture_rx.md
Name: video_capture_rx

Overview:
- Receive-side counterpart of the 480p parallel video output: samples HSYNC/VSYNC/DE/R/G/B on the pixel clock and recovers pixel coordinates.
- Checks timing against the expected active geometry and captures the 40x6 CRT window (R channel) into a double-buffered bitmap that can be read out.
- Used as a loopback checker on the board and as the scoreboard front end in simulation.

Parameters:
- H_ACTIVE, 640, expected DE-high pixels per line
- V_ACTIVE, 480, expected DE lines per frame
- WIN_W, 40, capture window width (columns 0..WIN_W-1)
- WIN_H, 6, capture window height (rows 0..WIN_H-1)
- CNT_W, 10, width of coordinate and measurement counters
- SYNC_ACT, 0, active level of hsync/vsync inputs (0 = negative sync)

Ports:
- clk_pix  in  1  pixel clock; all logic on rising edge
- rst_pix_n  in  1  synchronous active-low reset
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- de  in  1  data enable
- r, g, b  in  1 each  pixel colour bits; only r is captured
- px  out  CNT_W  recovered x of the current registered sample
- py  out  CNT_W  recovered y of the current registered sample
- px_valid  out  1  registered de; px/py are meaningful when high
- locked  out  1  two consecutive frames matched H_ACTIVE x V_ACTIVE
- line_err  out  1  sticky: a DE run length differed from H_ACTIVE while locked
- frame_done  out  1  one-cycle pulse when the back buffer is swapped to front
- meas_line  out  CNT_W  DE length of the last completed line
- meas_lines  out  CNT_W  DE line count of the last completed frame
- rd_row  in  3  bitmap read row
- rd_col  in  6  bitmap read column
- rd_data  out  1  front-buffer bit at (rd_row, rd_col), one cycle latency

Behaviour:
- Input stage: all six inputs are registered once (stage S1), then delayed once more (S2) for edge detection. Sync inputs are normalised by SYNC_ACT so that internal "sync asserted" = 1.
- vs_rise = S1 vsync asserted and S2 not asserted. de_rise and de_fall are defined the same way on de.
- x counter: cleared on de_rise, so the first active pixel is px=0. Increments while S1 de is high and saturates at 2^CNT_W-1.
- y counter: cleared on vs_rise. Increments on de_fall and saturates.
- px, py and px_valid are taken from S1, giving 2 cycles of latency from the pins.
- meas_line is loaded with the x count on de_fall.
- meas_lines is loaded with the y count on vs_rise, but only if the FSM is in ACTIVE.
- FSM states:
  - SEEK: wait for vs_rise -> WAIT.
  - WAIT: first de_rise -> ACTIVE.
  - ACTIVE: on vs_rise, evaluate the frame -> ACTIVE (new frame).
  - A frame is "good" when meas_lines == V_ACTIVE and every line in it had length H_ACTIVE.
  - good_cnt increments on a good frame (saturates at 2) and clears on a bad one.
  - locked = (good_cnt == 2); it drops the cycle after a bad-frame evaluation.
- line_err is set on a de_fall while locked with length != H_ACTIVE. It is cleared only by reset.
- Capture: when S1 de is high and px < WIN_W and py < WIN_H, write S1 r into the back buffer at (py, px). Nothing outside the window is written.
- Buffers: two banks of WIN_H x WIN_W bits, with bank select bsel.
  - Writes go to bank ~bsel; reads go to bank bsel.
  - On vs_rise in ACTIVE, bsel toggles and frame_done pulses for one cycle.
  - No swap occurs in SEEK or WAIT.
- Read port: rd_data is registered. An out-of-range rd_row or rd_col returns 0.
- Simultaneous de_fall and vs_rise: the line is counted first, then the frame is evaluated with the incremented count.
- Reset mid-frame: all outputs go to 0 (px, py, meas_*, locked, line_err, frame_done, rd_data), bsel=0 and FSM=SEEK. Bitmap contents are not cleared; the first frame after reset is not swapped in.

Decomposition:
- Package video_rx_pkg holds:
  - the state enum (SEEK, WAIT, ACTIVE)
  - localparams WIN_ROW_W=3 and WIN_COL_W=6
  - default 480p constants (640, 480)
- One sub-module: capture_bitmap. It is the dual-bank bit store with a write port, a registered read port and a bank select.

Test Plan:
- Reset, then drive 3 frames of standard 640x480 timing with de and negative syncs -> locked=1 after the third vs_rise; meas_line=640, meas_lines=480; line_err=0.
- Frame with r=1 only at (x=5, y=2) and (x=39, y=5), plus r=1 at (x=40, y=0) -> after frame_done, rd_data is 1 at (2,5) and (5,39), and 0 at (0,40) and all other cells.
- While locked, shorten one DE run to 639 -> meas_line=639 and line_err=1 (stays set). Also locked=0 after that frame's vs_rise.
- Frame with only 479 DE lines -> meas_lines=479 and locked drops. Two following good frames -> locked=1.
- Assert rst_pix_n=0 for 1 cycle mid-line at y=3 -> all outputs 0 next cycle. The first vs_rise after reset gives no frame_done; the second vs_rise gives a frame_done pulse.
- Apply de_fall and vs_rise on the same cycle after line 480 -> meas_lines=480 and the frame evaluates as good.
